render_controller: RTL and testbench
====================================

// Module: render_controller
// PURPOSE
//  Frame sequencer in front of multi_solver: owns view window (min_x/min_y/dx/dy, signed Q4.23, 27 b).
//  Accepts pan/zoom/home commands over valid/ready, recomputes the window, pulses solver reset, waits
//  for solver done, then flags the frame complete for the display path. Sits between user input and multi_solver.
// PARAMETERS
//  NUM_COLUMNS   640        frame width in pixels (zoom-centre math)
//  NUM_ROWS      480        frame height in pixels (zoom-centre math)
//  RESET_CYCLES  2          solver_reset pulse length, >=1
//  PAN_SHIFT     5          pan step = d << PAN_SHIFT (32 px)
//  HOME_MIN_X    -16777216  home min_x (-2.0)
//  HOME_MIN_Y    -9437184   home min_y (-1.125)
//  HOME_D        39322      home dx = dy (~3.0/640)
//  MAX_D         1048576    zoom-out ceiling for dx/dy (0.125)
// PORTS
//  clock         in   1   system clock
//  reset         in   1   asynchronous, active-low (0 = reset)
//  cmd_valid     in   1   command present
//  cmd_op        in   3   0 HOME,1 LEFT,2 RIGHT,3 UP,4 DOWN,5 ZOOM_IN,6 ZOOM_OUT,7 REDRAW
//  cmd_ready     out  1   command accepted when valid & ready at posedge
//  solver_done   in   1   multi_solver done
//  solver_reset  out  1   active-high sync reset to multi_solver
//  min_x,min_y   out  27  signed window origin
//  dx,dy         out  27  signed pixel pitch (always equal)
//  frame_ready   out  1   current window fully rendered
//  frame_count   out  16  completed frames, wraps at 0xFFFF -> 0
// BEHAVIOUR
//  - Reset (async assert, sync release): min/d = HOME values, solver_reset=1, cmd_ready=0,
//    frame_ready=0, frame_count=0, state=START with pulse counter cleared.
//  - FSM: START -> SETTLE -> RUN -> IDLE.
//    START: solver_reset=1 for exactly RESET_CYCLES cycles, then SETTLE.
//    SETTLE: one cycle, solver_done ignored (stale done masked), then RUN.
//    RUN: solver_done=1 -> IDLE, frame_ready=1 next cycle, frame_count+1.
//    IDLE: hold; frame_ready=1.
//  - cmd_ready=1 in RUN and IDLE, 0 in START/SETTLE. Accept at edge N: window regs updated at N+1,
//    frame_ready=0 and solver_reset=1 from N+1, state=START (aborts an in-progress RUN).
//  - Accept and solver_done in same RUN cycle: command wins, frame_count unchanged.
//  - Ops: LEFT/RIGHT min_x -/+ (dx<<PAN_SHIFT); UP/DOWN min_y -/+ (dy<<PAN_SHIFT);
//    ZOOM_IN d>>>1; ZOOM_OUT d<<1; HOME loads HOME_*; REDRAW window unchanged, re-render.
//  - ZOOM_IN with d==1, ZOOM_OUT with d>=MAX_D: window unchanged, command still accepted, re-render.
//  - min_x/min_y sums computed 38 b wide, saturated to [-2^26, 2^26-1]; never wrap.
// CONFIGURATION
//  RENDER_ZOOM_CENTER_EN defined: zoom keeps window centre fixed:
//    ZOOM_IN  min_x += (dx*NUM_COLUMNS)>>>2, min_y += (dy*NUM_ROWS)>>>2 (old d);
//    ZOOM_OUT min_x -= (dx*NUM_COLUMNS)>>>1, min_y -= (dy*NUM_ROWS)>>>1 (old d); both saturated.
//  Not defined: zoom anchors top-left; min_x/min_y unchanged by zoom; no multipliers synthesised.
//  Ignored zooms (d limit) leave min unchanged in both builds.
// STRUCTURE
//  Shared header render_defs.v: cmd_op codes, state encodings, Q4.23 width (27), saturation bounds.
//  Sub-module view_update (combinational): {op, min_x, min_y, d} -> next {min_x, min_y, d};
//    holds all saturation and zoom-centre math; controller holds FSM, registers, counters.
// TESTING
//  1 Release reset, hold solver_done=0 -> solver_reset high exactly 2 cycles, min_x=-16777216,
//    dx=39322; done=1 -> frame_ready=1, frame_count=1.
//  2 IDLE, RIGHT -> min_x=-16777216+39322*32=-15518912, frame_ready drops next cycle, re-render.
//  3 RUN, ZOOM_IN same cycle as solver_done -> frame_count unchanged, dx=19661, restart.
//  4 ZOOM_IN until dx=1, once more -> dx stays 1, accepted, re-render; ZOOM_OUT from 1048576 -> unchanged.
//  5 min_x=2^26-100, RIGHT -> min_x=67108863 (saturated); LEFT from -2^26+5 -> -67108864.
//  6 RENDER_ZOOM_CENTER_EN, HOME then ZOOM_IN -> min_x=-16777216+(39322*640>>2)=-10485696, dx=19661;
//    assert reset low mid-RUN -> all outputs to reset values immediately.

Source files
------------

// File: rtl/render_controller_pkg.sv
// Shared definitions for the render controller: command codes, FSM states,
// Q4.23 coordinate width and the saturation helper for window origin updates.
package render_controller_pkg;

  localparam int unsigned COORD_W = 27;
  localparam int unsigned WIDE_W  = 38;

  localparam logic signed [WIDE_W-1:0] SAT_HI = 38'sd67108863;
  localparam logic signed [WIDE_W-1:0] SAT_LO = -38'sd67108864;

  typedef enum logic [2:0] {
    OP_HOME     = 3'd0,
    OP_LEFT     = 3'd1,
    OP_RIGHT    = 3'd2,
    OP_UP       = 3'd3,
    OP_DOWN     = 3'd4,
    OP_ZOOM_IN  = 3'd5,
    OP_ZOOM_OUT = 3'd6,
    OP_REDRAW   = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_START,
    ST_SETTLE,
    ST_RUN,
    ST_IDLE
  } state_e;

  // Clamp a wide sum back into the 27-bit signed coordinate range.
  function automatic logic signed [COORD_W-1:0] sat_coord(input logic signed [WIDE_W-1:0] v);
    logic signed [COORD_W-1:0] r;
    if (v > SAT_HI)      r = SAT_HI[COORD_W-1:0];
    else if (v < SAT_LO) r = SAT_LO[COORD_W-1:0];
    else                 r = v[COORD_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/render_controller_view_update.sv
// Combinational next-window computation for one command: pans, zooms, home.
// Build option RENDER_ZOOM_CENTER_EN keeps the window centre fixed across zooms.
module view_update
  import render_controller_pkg::*;
#(
  parameter int          NUM_COLUMNS = 640,
  parameter int          NUM_ROWS    = 480,
  parameter int unsigned PAN_SHIFT   = 5,
  parameter int          HOME_MIN_X  = -16777216,
  parameter int          HOME_MIN_Y  = -9437184,
  parameter int          HOME_D      = 39322,
  parameter int          MAX_D       = 1048576
) (
  input  logic [2:0]  i_op,
  input  logic [26:0] i_min_x,
  input  logic [26:0] i_min_y,
  input  logic [26:0] i_d,
  output logic [26:0] o_min_x,
  output logic [26:0] o_min_y,
  output logic [26:0] o_d
);

  localparam logic signed [WIDE_W-1:0] MAX_D_W = WIDE_W'(MAX_D);
  localparam logic signed [WIDE_W-1:0] COLS_W  = WIDE_W'(NUM_COLUMNS);
  localparam logic signed [WIDE_W-1:0] ROWS_W  = WIDE_W'(NUM_ROWS);

  logic signed [WIDE_W-1:0] w_min_x;
  logic signed [WIDE_W-1:0] w_min_y;
  logic signed [WIDE_W-1:0] w_d;
  logic signed [WIDE_W-1:0] w_step;
  logic signed [WIDE_W-1:0] w_span_x;
  logic signed [WIDE_W-1:0] w_span_y;

  assign w_min_x = {{(WIDE_W-COORD_W){i_min_x[COORD_W-1]}}, i_min_x};
  assign w_min_y = {{(WIDE_W-COORD_W){i_min_y[COORD_W-1]}}, i_min_y};
  assign w_d     = {{(WIDE_W-COORD_W){i_d[COORD_W-1]}}, i_d};
  assign w_step  = w_d <<< PAN_SHIFT;

`ifdef RENDER_ZOOM_CENTER_EN
  assign w_span_x = w_d * COLS_W;
  assign w_span_y = w_d * ROWS_W;
`else
  // Top-left anchored zoom: spans are constant zero so no multipliers are built.
  assign w_span_x = COLS_W & '0;
  assign w_span_y = ROWS_W & '0;
`endif

  always_comb begin
    o_min_x = i_min_x;
    o_min_y = i_min_y;
    o_d     = i_d;
    case (cmd_op_e'(i_op))
      OP_HOME: begin
        o_min_x = COORD_W'(HOME_MIN_X);
        o_min_y = COORD_W'(HOME_MIN_Y);
        o_d     = COORD_W'(HOME_D);
      end
      OP_LEFT:  o_min_x = sat_coord(w_min_x - w_step);
      OP_RIGHT: o_min_x = sat_coord(w_min_x + w_step);
      OP_UP:    o_min_y = sat_coord(w_min_y - w_step);
      OP_DOWN:  o_min_y = sat_coord(w_min_y + w_step);
      OP_ZOOM_IN: begin
        if (i_d != 27'd1) begin
          o_min_x = sat_coord(w_min_x + (w_span_x >>> 2));
          o_min_y = sat_coord(w_min_y + (w_span_y >>> 2));
          o_d     = $signed(i_d) >>> 1;
        end
      end
      OP_ZOOM_OUT: begin
        if (w_d < MAX_D_W) begin
          o_min_x = sat_coord(w_min_x - (w_span_x >>> 1));
          o_min_y = sat_coord(w_min_y - (w_span_y >>> 1));
          o_d     = i_d << 1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/render_controller.sv
// Frame sequencer in front of multi_solver: holds the view window, applies
// commands, pulses solver reset and tracks frame completion (RENDER_ZOOM_CENTER_EN).
module render_controller
  import render_controller_pkg::*;
#(
  parameter int          NUM_COLUMNS  = 640,
  parameter int          NUM_ROWS     = 480,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned PAN_SHIFT    = 5,
  parameter int          HOME_MIN_X   = -16777216,
  parameter int          HOME_MIN_Y   = -9437184,
  parameter int          HOME_D       = 39322,
  parameter int          MAX_D        = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  output logic        cmd_ready,
  input  logic        solver_done,
  output logic        solver_reset,
  output logic [26:0] min_x,
  output logic [26:0] min_y,
  output logic [26:0] dx,
  output logic [26:0] dy,
  output logic        frame_ready,
  output logic [15:0] frame_count
);

  localparam int unsigned CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [26:0]      r_min_x;
  logic [26:0]      r_min_y;
  logic [26:0]      r_d;
  logic             r_cmd_ready;
  logic             r_solver_reset;
  logic             r_frame_ready;
  logic [15:0]      r_frame_count;

  logic [26:0] w_next_min_x;
  logic [26:0] w_next_min_y;
  logic [26:0] w_next_d;
  logic        w_accept;

  assign w_accept = cmd_valid & r_cmd_ready;

  view_update #(
    .NUM_COLUMNS (NUM_COLUMNS),
    .NUM_ROWS    (NUM_ROWS),
    .PAN_SHIFT   (PAN_SHIFT),
    .HOME_MIN_X  (HOME_MIN_X),
    .HOME_MIN_Y  (HOME_MIN_Y),
    .HOME_D      (HOME_D),
    .MAX_D       (MAX_D)
  ) u_view_update (
    .i_op    (cmd_op),
    .i_min_x (r_min_x),
    .i_min_y (r_min_y),
    .i_d     (r_d),
    .o_min_x (w_next_min_x),
    .o_min_y (w_next_min_y),
    .o_d     (w_next_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_START;
      r_cnt          <= '0;
      r_min_x        <= COORD_W'(HOME_MIN_X);
      r_min_y        <= COORD_W'(HOME_MIN_Y);
      r_d            <= COORD_W'(HOME_D);
      r_cmd_ready    <= 1'b0;
      r_solver_reset <= 1'b1;
      r_frame_ready  <= 1'b0;
      r_frame_count  <= '0;
    end else if (w_accept) begin
      // A command outranks a same-cycle solver_done and aborts any render in flight.
      r_min_x        <= w_next_min_x;
      r_min_y        <= w_next_min_y;
      r_d            <= w_next_d;
      r_state        <= ST_START;
      r_cnt          <= '0;
      r_cmd_ready    <= 1'b0;
      r_solver_reset <= 1'b1;
      r_frame_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          if (r_cnt == CNT_LAST) begin
            r_state        <= ST_SETTLE;
            r_solver_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          r_state     <= ST_RUN;
          r_cmd_ready <= 1'b1;
        end
        ST_RUN: begin
          if (solver_done) begin
            r_state       <= ST_IDLE;
            r_frame_ready <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end
        end
        ST_IDLE: ;
        default: r_state <= ST_START;
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign solver_reset = r_solver_reset;
  assign min_x        = r_min_x;
  assign min_y        = r_min_y;
  assign dx           = r_d;
  assign dy           = r_d;
  assign frame_ready  = r_frame_ready;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_render_controller.sv
// Self-checking bench for render_controller: directed scenarios plus random
// commands, compared every cycle against a window/phase model.
module tb_render_controller;

  localparam int RC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic        solver_done = 1'b0;
  logic        cmd_ready;
  logic        solver_reset;
  logic [26:0] min_x;
  logic [26:0] min_y;
  logic [26:0] dx;
  logic [26:0] dy;
  logic        frame_ready;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;

  longint m_minx;
  longint m_miny;
  longint m_d;
  int     m_age;
  bit     m_done;
  int     m_count;

  always #5 clock = ~clock;

  render_controller dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_ready    (cmd_ready),
    .solver_done  (solver_done),
    .solver_reset (solver_reset),
    .min_x        (min_x),
    .min_y        (min_y),
    .dx           (dx),
    .dy           (dy),
    .frame_ready  (frame_ready),
    .frame_count  (frame_count)
  );

  function automatic logic signed [63:0] s27(input logic [26:0] v);
    return 64'($signed(v));
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 67108863) return 67108863;
    if (v < -67108864) return -67108864;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return m_age >= RC + 1;
  endfunction

  task automatic model_reset();
    m_minx  = -16777216;
    m_miny  = -9437184;
    m_d     = 39322;
    m_age   = 0;
    m_done  = 0;
    m_count = 0;
  endtask

  task automatic apply_op(input int op);
    case (op)
      0: begin m_minx = -16777216; m_miny = -9437184; m_d = 39322; end
      1: m_minx = clamp(m_minx - m_d * 32);
      2: m_minx = clamp(m_minx + m_d * 32);
      3: m_miny = clamp(m_miny - m_d * 32);
      4: m_miny = clamp(m_miny + m_d * 32);
      5: if (m_d != 1) begin
`ifdef RENDER_ZOOM_CENTER_EN
           m_minx = clamp(m_minx + (m_d * 640) / 4);
           m_miny = clamp(m_miny + (m_d * 480) / 4);
`endif
           m_d = m_d / 2;
         end
      6: if (m_d < 1048576) begin
`ifdef RENDER_ZOOM_CENTER_EN
           m_minx = clamp(m_minx - (m_d * 640) / 2);
           m_miny = clamp(m_miny - (m_d * 480) / 2);
`endif
           m_d = m_d * 2;
         end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    if (cmd_valid && m_ready()) begin
      apply_op(int'(cmd_op));
      m_age  = 0;
      m_done = 0;
    end else begin
      if (m_ready() && !m_done && solver_done) begin
        m_done  = 1;
        m_count = (m_count + 1) % 65536;
      end
      if (m_age < 1000) m_age++;
    end
  endtask

  task automatic check_all();
    chk("cmd_ready",    64'(cmd_ready),    64'(m_ready()));
    chk("solver_reset", 64'(solver_reset), 64'(m_age < RC));
    chk("min_x",        s27(min_x),        m_minx);
    chk("min_y",        s27(min_y),        m_miny);
    chk("dx",           s27(dx),           m_d);
    chk("dy",           s27(dy),           m_d);
    chk("frame_ready",  64'(frame_ready),  64'(m_done));
    chk("frame_count",  64'(frame_count),  64'(m_count));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !m_ready(); i++) step();
    if (!m_ready()) chk("ready_timeout", 64'(cmd_ready), 64'(1));
  endtask

  task automatic issue(input int op);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic render();
    solver_done = 1'b1;
    for (int i = 0; i < 20 && !m_done; i++) step();
    solver_done = 1'b0;
    if (!m_done) chk("render_timeout", 64'(frame_ready), 64'(1));
  endtask

  initial begin
    int hi;
    model_reset();
    repeat (3) @(negedge clock);
    check_all();
    chk("rst_solver_reset", 64'(solver_reset), 64'(1));
    chk("rst_min_x",        s27(min_x),        -64'sd16777216);

    // Release reset and measure the solver reset pulse.
    reset = 1'b1;
    check_all();
    hi = solver_reset ? 1 : 0;
    repeat (5) begin
      step();
      if (solver_reset) hi++;
    end
    chk("sr_pulse_len", 64'(hi), 64'(2));
    chk("home_dx", s27(dx), 64'sd39322);
    render();
    chk("first_frame_ready", 64'(frame_ready), 64'(1));
    chk("first_frame_count", 64'(frame_count), 64'(1));

    issue(2);
    chk("right_min_x",       s27(min_x),        -64'sd15518912);
    chk("right_frame_ready", 64'(frame_ready),  64'(0));
    chk("right_sr",          64'(solver_reset), 64'(1));
    render();
    chk("second_count", 64'(frame_count), 64'(2));

    // Command and solver_done in the same RUN cycle.
    wait_ready();
    cmd_valid   = 1'b1;
    cmd_op      = 3'd5;
    solver_done = 1'b1;
    step();
    cmd_valid   = 1'b0;
    solver_done = 1'b0;
    chk("race_count", 64'(frame_count), 64'(2));
    chk("race_dx",    s27(dx),          64'sd19661);
    chk("race_sr",    64'(solver_reset), 64'(1));

    for (int i = 0; i < 40 && m_d != 1; i++) issue(5);
    chk("zoom_in_floor", s27(dx), 64'sd1);
    issue(5);
    chk("zoom_in_ignored", s27(dx), 64'sd1);
    chk("zoom_in_ign_sr",  64'(solver_reset), 64'(1));
    chk("zoom_in_ign_rdy", 64'(cmd_ready), 64'(0));
    for (int i = 0; i < 40 && m_d < 1048576; i++) issue(6);
    chk("zoom_out_ceiling", s27(dx), 64'sd1048576);
    issue(6);
    chk("zoom_out_ignored", s27(dx), 64'sd1048576);
    chk("zoom_out_ign_sr",  64'(solver_reset), 64'(1));

    repeat (4) issue(2);
    chk("sat_right", s27(min_x), 64'sd67108863);
    repeat (5) issue(1);
    chk("sat_left",  s27(min_x), -64'sd67108864);
    repeat (5) issue(4);
    chk("sat_down",  s27(min_y), 64'sd67108863);
    repeat (5) issue(3);
    chk("sat_up",    s27(min_y), -64'sd67108864);

    issue(0);
    issue(5);
`ifdef RENDER_ZOOM_CENTER_EN
    chk("centre_min_x", s27(min_x), -64'sd10485696);
    chk("centre_min_y", s27(min_y), -64'sd4718544);
`else
    chk("anchor_min_x", s27(min_x), -64'sd16777216);
    chk("anchor_min_y", s27(min_y), -64'sd9437184);
`endif
    chk("home_zoom_dx", s27(dx), 64'sd19661);

    repeat (600) begin
      cmd_valid   = ($urandom_range(0, 99) < 20);
      cmd_op      = 3'($urandom_range(0, 7));
      solver_done = ($urandom_range(0, 99) < 25);
      step();
    end
    cmd_valid   = 1'b0;
    solver_done = 1'b0;

    // Asynchronous reset in the middle of a render.
    issue(7);
    wait_ready();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_sr",    64'(solver_reset), 64'(1));
    chk("async_rst_count", 64'(frame_count),  64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check_all();
    repeat (6) step();
    render();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
